router_input_port: RTL and testbench

Input stage of a 2D-mesh router port. It accepts flits from the upstream link over an RTS/CTS handshake and buffers them in a small FIFO. It computes the XY route from each header flit and drives one-hot per-output requests (Req_N/E/W/S/L) to the output arbiters. The flit at the head of the FIFO is popped on grant, and the request is held for the whole packet, header through tail.

---
 rtl/router_input_port.sv | 206 ++++++++++++++++++++
 tb/tb_router_input_port.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// router_input_port: input stage of a 2D-mesh router port.
// Accepts flits over an RTS/CTS handshake into a small FIFO, computes the
// XY route from each header flit and holds a one-hot output request for
// the whole packet until its tail flit is popped.
module router_input_port #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CUR_X      = 0,
   parameter int CUR_Y      = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] RX,
   input  logic                  DRTS,
   output logic                  CTS,
   input  logic                  Grant,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  Req_N,
   output logic                  Req_E,
   output logic                  Req_W,
   output logic                  Req_S,
   output logic                  Req_L,
   output logic                  empty,
   output logic                  full,
   output logic                  err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(1'b0);
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);

   localparam logic [3:0] CUR_X_C = 4'(CUR_X);
   localparam logic [3:0] CUR_Y_C = 4'(CUR_Y);

   localparam logic [2:0] TYPE_HEADER_C = 3'b001;
   localparam logic [2:0] TYPE_TAIL_C   = 3'b100;

   // One-hot request encoding: bit 0 N, 1 E, 2 W, 3 S, 4 L.
   localparam logic [4:0] REQ_NONE_C = 5'b00000;
   localparam logic [4:0] REQ_N_C    = 5'b00001;
   localparam logic [4:0] REQ_E_C    = 5'b00010;
   localparam logic [4:0] REQ_W_C    = 5'b00100;
   localparam logic [4:0] REQ_S_C    = 5'b01000;
   localparam logic [4:0] REQ_L_C    = 5'b10000;

   typedef enum logic {
      IDLE   = 1'b0,
      ROUTED = 1'b1
   } state_t;

   logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  cts_r;
   logic                  err_r;
   logic [4:0]            req_r;
   state_t                state_r;

   state_t                state_s;
   logic [4:0]            req_s;
   logic                  err_s;
   logic                  pop_s;
   logic                  wr_en_s;
   logic                  empty_s;
   logic                  full_s;
   logic [2:0]            head_type_s;

   // XY dimension-order route: resolve X first, then Y, else local.
   // Signed 5-bit differences avoid constant compares when CUR is 0 or 15.
   function automatic logic [4:0] xy_route(input logic [3:0] dest_x,
                                           input logic [3:0] dest_y);
      logic [4:0] dx_v;
      logic [4:0] dy_v;
      logic [4:0] req_v;
      dx_v = {1'b0, dest_x} - {1'b0, CUR_X_C};
      dy_v = {1'b0, dest_y} - {1'b0, CUR_Y_C};
      if (dx_v != 5'd0) begin
         if (dx_v[4]) begin
            req_v = REQ_W_C;
         end else begin
            req_v = REQ_E_C;
         end
      end else if (dy_v != 5'd0) begin
         if (dy_v[4]) begin
            req_v = REQ_N_C;
         end else begin
            req_v = REQ_S_C;
         end
      end else begin
         req_v = REQ_L_C;
      end
      return req_v;
   endfunction

   assign empty_s     = (count_r == CNT_ZERO_C);
   assign full_s      = (count_r == DEPTH_C);
   assign Data_out    = mem_r[rd_ptr_r];
   assign head_type_s = Data_out[DATA_WIDTH-1 -: 3];
   // full is taken from the registered count, so a pop in the same cycle
   // never lets a write through.
   assign wr_en_s     = DRTS & ~cts_r & ~full_s;

   assign CTS   = cts_r;
   assign Req_N = req_r[0];
   assign Req_E = req_r[1];
   assign Req_W = req_r[2];
   assign Req_S = req_r[3];
   assign Req_L = req_r[4];
   assign empty = empty_s;
   assign full  = full_s;
   assign err   = err_r;

   // Route FSM next state: route headers in IDLE, drain the packet on grant in ROUTED.
   always_comb begin
      state_s = state_r;
      req_s   = req_r;
      err_s   = err_r;
      pop_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               if (head_type_s == TYPE_HEADER_C) begin
                  state_s = ROUTED;
                  req_s   = xy_route(Data_out[7:4], Data_out[3:0]);
               end else begin
                  // Orphan body/tail with no header: discard and flag.
                  pop_s = 1'b1;
                  err_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ROUTED: begin
            if (Grant && !empty_s) begin
               pop_s = 1'b1;
               if (head_type_s == TYPE_TAIL_C) begin
                  state_s = IDLE;
                  req_s   = REQ_NONE_C;
               end else begin
                  state_s = ROUTED;
               end
            end else begin
               state_s = ROUTED;
            end
         end
         default: begin
            state_s = IDLE;
            req_s   = REQ_NONE_C;
         end
      endcase
   end

   // FIFO storage: cleared on reset, written at wr_ptr on an accepted flit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         mem_r[wr_ptr_r] <= RX;
      end
   end

   // FIFO pointers and occupancy; simultaneous write and pop keep count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= CNT_ZERO_C;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
         case ({wr_en_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE_C;
            2'b01:   count_r <= count_r - CNT_ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   // Handshake pulse, route state, held request and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cts_r   <= 1'b0;
         state_r <= IDLE;
         req_r   <= REQ_NONE_C;
         err_r   <= 1'b0;
      end else begin
         cts_r   <= wr_en_s;
         state_r <= state_s;
         req_r   <= req_s;
         err_r   <= err_s;
      end
   end

endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: directed bench with a queue-based packet model that
// is compared against the DUT on every falling edge.
module tb_router_input_port;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CX    = 0;
   localparam int CY    = 0;

   localparam logic [2:0] T_HDR  = 3'b001;
   localparam logic [2:0] T_BODY = 3'b010;
   localparam logic [2:0] T_TAIL = 3'b100;

   // Expected request vectors ordered {N,E,W,S,L}.
   localparam logic [4:0] E_N = 5'b10000;
   localparam logic [4:0] E_E = 5'b01000;
   localparam logic [4:0] E_W = 5'b00100;
   localparam logic [4:0] E_S = 5'b00010;
   localparam logic [4:0] E_L = 5'b00001;
   localparam logic [4:0] E_0 = 5'b00000;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] RX;
   logic          DRTS;
   logic          CTS;
   logic          Grant;
   logic [DW-1:0] Data_out;
   logic          Req_N, Req_E, Req_W, Req_S, Req_L;
   logic          empty, full, err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // Model state: contents of the buffer as a queue plus packet status.
   logic [DW-1:0] m_q[$];
   bit            m_routed;
   logic [4:0]    m_req;
   bit            m_err;
   bit            m_cts;

   router_input_port #(
      .DATA_WIDTH(DW),
      .FIFO_DEPTH(DEPTH),
      .CUR_X     (CX),
      .CUR_Y     (CY)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .RX      (RX),
      .DRTS    (DRTS),
      .CTS     (CTS),
      .Grant   (Grant),
      .Data_out(Data_out),
      .Req_N   (Req_N),
      .Req_E   (Req_E),
      .Req_W   (Req_W),
      .Req_S   (Req_S),
      .Req_L   (Req_L),
      .empty   (empty),
      .full    (full),
      .err     (err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] flit(input logic [2:0] t, input logic [7:0] tag,
                                          input logic [3:0] x, input logic [3:0] y);
      return {t, 13'd0, tag, x, y};
   endfunction

   // XY routing rule stated directly on coordinates.
   function automatic logic [4:0] exp_route(input logic [DW-1:0] f);
      int dx;
      int dy;
      dx = int'(f[7:4]);
      dy = int'(f[3:0]);
      if (dx > CX) return E_E;
      if (dx < CX) return E_W;
      if (dy < CY) return E_N;
      if (dy > CY) return E_S;
      return E_L;
   endfunction

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
   endtask

   // Advance the model by one rising edge using the inputs about to be sampled.
   task automatic model_step();
      logic [DW-1:0] head;
      bit            do_wr;
      bit            do_pop;
      if (rst) begin
         m_q.delete();
         m_routed = 1'b0;
         m_req    = E_0;
         m_err    = 1'b0;
         m_cts    = 1'b0;
         return;
      end
      do_wr  = DRTS && !m_cts && (m_q.size() < DEPTH);
      do_pop = 1'b0;
      head   = (m_q.size() != 0) ? m_q[0] : {DW{1'b0}};
      if (!m_routed) begin
         if (m_q.size() != 0) begin
            if (head[31:29] == T_HDR) begin
               m_routed = 1'b1;
               m_req    = exp_route(head);
            end else begin
               do_pop = 1'b1;
               m_err  = 1'b1;
            end
         end
      end else if (Grant && m_q.size() != 0) begin
         do_pop = 1'b1;
         if (head[31:29] == T_TAIL) begin
            m_routed = 1'b0;
            m_req    = E_0;
         end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_wr) m_q.push_back(RX);
      m_cts = do_wr;
   endtask

   // Compare DUT outputs against the model, then step the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_CTS", {31'd0, CTS}, {31'd0, m_cts});
         check("cmp_Req", {27'd0, Req_N, Req_E, Req_W, Req_S, Req_L}, {27'd0, m_req});
         check("cmp_empty", {31'd0, empty}, {31'd0, m_q.size() == 0});
         check("cmp_full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
         check("cmp_err", {31'd0, err}, {31'd0, m_err});
         if (m_q.size() != 0) check("cmp_Data_out", Data_out, m_q[0]);
      end
      model_step();
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Offer one flit and hold it until CTS is seen.
   task automatic send(input logic [DW-1:0] f, output int acc_cyc);
      RX      = f;
      DRTS    = 1'b1;
      acc_cyc = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (CTS) begin
            acc_cyc = cyc;
            DRTS    = 1'b0;
            return;
         end
      end
      DRTS = 1'b0;
      timeout("send_cts");
   endtask

   task automatic wait_empty(input string nm);
      for (int i = 0; i < 40; i++) begin
         if (empty) return;
         tick();
      end
      timeout(nm);
   endtask

   function automatic logic [DW-1:0] reqv();
      return {27'd0, Req_N, Req_E, Req_W, Req_S, Req_L};
   endfunction

   initial begin
      int c0, c1, c2, c3, cx;
      rst   = 1'b1;
      DRTS  = 1'b0;
      Grant = 1'b0;
      RX    = {DW{1'b0}};

      // Pin the routing model with hand-computed cases.
      check("pin_route_2_0", {27'd0, exp_route(flit(T_HDR, 8'h00, 4'd2, 4'd0))}, {27'd0, E_E});
      check("pin_route_0_3", {27'd0, exp_route(flit(T_HDR, 8'h00, 4'd0, 4'd3))}, {27'd0, E_S});
      check("pin_route_0_0", {27'd0, exp_route(flit(T_HDR, 8'h00, 4'd0, 4'd0))}, {27'd0, E_L});

      tick();
      tick();
      tick();
      check("rst_CTS", {31'd0, CTS}, 32'd0);
      check("rst_Req", reqv(), 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_Data_out", Data_out, 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Header to (2,0) from (0,0): east request one edge after it lands.
      send(flit(T_HDR, 8'h01, 4'd2, 4'd0), c0);
      check("t1_empty_drop", {31'd0, empty}, 32'd0);
      check("t1_Req_before", reqv(), 32'd0);
      tick();
      check("t1_Req_E", reqv(), {27'd0, E_E});
      check("t1_CTS_low", {31'd0, CTS}, 32'd0);
      Grant = 1'b1;
      send(flit(T_TAIL, 8'h02, 4'd0, 4'd0), cx);
      wait_empty("t1_drain");
      tick();
      Grant = 1'b0;
      check("t1_Req_clear", reqv(), 32'd0);

      // Three-flit local packet drained with Grant held high.
      send(flit(T_HDR, 8'h10, 4'd0, 4'd0), cx);
      send(flit(T_BODY, 8'hAA, 4'd5, 4'd5), cx);
      send(flit(T_TAIL, 8'hBB, 4'd6, 4'd6), cx);
      check("t2_head", Data_out, flit(T_HDR, 8'h10, 4'd0, 4'd0));
      check("t2_Req_L", reqv(), {27'd0, E_L});
      Grant = 1'b1;
      tick();
      check("t2_body", Data_out, flit(T_BODY, 8'hAA, 4'd5, 4'd5));
      check("t2_Req_L_held", reqv(), {27'd0, E_L});
      tick();
      check("t2_tail", Data_out, flit(T_TAIL, 8'hBB, 4'd6, 4'd6));
      check("t2_Req_L_held2", reqv(), {27'd0, E_L});
      tick();
      check("t2_Req_drop", reqv(), 32'd0);
      check("t2_empty", {31'd0, empty}, 32'd1);
      Grant = 1'b0;
      tick();

      // Fill with Grant low: CTS every two cycles, then blocked at full.
      send(flit(T_HDR, 8'h20, 4'd0, 4'd0), c0);
      send(flit(T_BODY, 8'h21, 4'd1, 4'd1), c1);
      send(flit(T_BODY, 8'h22, 4'd2, 4'd2), c2);
      send(flit(T_BODY, 8'h23, 4'd3, 4'd3), c3);
      check("t3_spacing1", c1 - c0, 32'd2);
      check("t3_spacing2", c2 - c1, 32'd2);
      check("t3_spacing3", c3 - c2, 32'd2);
      check("t3_full", {31'd0, full}, 32'd1);
      RX   = flit(T_TAIL, 8'h24, 4'd4, 4'd4);
      DRTS = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_no_cts_full", {31'd0, CTS}, 32'd0);
      end
      Grant = 1'b1;
      tick();
      Grant = 1'b0;
      check("t3_full_clear", {31'd0, full}, 32'd0);
      check("t3_no_cts_pop_edge", {31'd0, CTS}, 32'd0);
      check("t3_head_after_pop", Data_out, flit(T_BODY, 8'h21, 4'd1, 4'd1));
      tick();
      check("t3_cts_after_pop", {31'd0, CTS}, 32'd1);
      DRTS  = 1'b0;
      Grant = 1'b1;
      wait_empty("t3_drain");
      tick();
      Grant = 1'b0;
      check("t3_Req_clear", reqv(), 32'd0);

      // Orphan body flit in IDLE: discarded without Grant, err sticks.
      send(flit(T_BODY, 8'h30, 4'd1, 4'd0), cx);
      tick();
      check("t4_err", {31'd0, err}, 32'd1);
      check("t4_empty", {31'd0, empty}, 32'd1);
      check("t4_no_req", reqv(), 32'd0);
      tick();
      tick();
      tick();
      check("t4_err_sticky", {31'd0, err}, 32'd1);

      // Simultaneous write and pop at count 2, then a 10-flit packet wraps pointers.
      send(flit(T_HDR, 8'h40, 4'd0, 4'd0), cx);
      send(flit(T_BODY, 8'h41, 4'd1, 4'd1), cx);
      tick();
      RX    = flit(T_BODY, 8'h42, 4'd2, 4'd2);
      DRTS  = 1'b1;
      Grant = 1'b1;
      tick();
      DRTS  = 1'b0;
      check("t5_cts_with_pop", {31'd0, CTS}, 32'd1);
      check("t5_head", Data_out, flit(T_BODY, 8'h41, 4'd1, 4'd1));
      check("t5_not_empty", {31'd0, empty}, 32'd0);
      check("t5_not_full", {31'd0, full}, 32'd0);
      check("t5_model_count", m_q.size(), 32'd2);
      for (int i = 3; i <= 8; i++) begin
         send(flit(T_BODY, 8'(8'h40 + i), 4'(i), 4'(i)), cx);
      end
      send(flit(T_TAIL, 8'h49, 4'd9, 4'd9), cx);
      wait_empty("t5_drain");
      tick();
      Grant = 1'b0;
      check("t5_Req_clear", reqv(), 32'd0);
      check("t5_err_still", {31'd0, err}, 32'd1);

      // Reset mid-packet with a south request and three flits buffered.
      send(flit(T_HDR, 8'h50, 4'd0, 4'd3), cx);
      send(flit(T_BODY, 8'h51, 4'd1, 4'd1), cx);
      send(flit(T_BODY, 8'h52, 4'd2, 4'd2), cx);
      check("t6_Req_S", reqv(), {27'd0, E_S});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_Req_clear", reqv(), 32'd0);
      check("t6_empty", {31'd0, empty}, 32'd1);
      check("t6_full", {31'd0, full}, 32'd0);
      check("t6_CTS", {31'd0, CTS}, 32'd0);
      check("t6_err", {31'd0, err}, 32'd0);
      check("t6_Data_out", Data_out, 32'd0);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
